// File: rtl/alu_arbiter_if.sv
// Purpose : bundles the two requester ports and the alu connection shared by alu_arbiter.
// Latency : none, wires only.
// Backpressure: requesters hold req with stable operands until their done pulse.
//
// Ports (slave = arbiter side):
//   req0/a0/b0/op0, req1/a1/b1/op1 : requester inputs
//   alu_a/alu_b/alu_c              : registered operands to the alu
//   alu_d                          : combinational alu result
//   res, done0, done1, busy, gnt_id: result and status back to the requesters
interface alu_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             op0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             op1;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_c;
    logic [WIDTH-1:0] alu_d;
    logic [WIDTH-1:0] res;
    logic             done0;
    logic             done1;
    logic             busy;
    logic             gnt_id;

    // Arbiter side.
    modport slave (
        input  req0, a0, b0, op0,
        input  req1, a1, b1, op1,
        input  alu_d,
        output alu_a, alu_b, alu_c,
        output res, done0, done1, busy, gnt_id
    );

    // Requester/alu side.
    modport master (
        output req0, a0, b0, op0,
        output req1, a1, b1, op1,
        output alu_d,
        input  alu_a, alu_b, alu_c,
        input  res, done0, done1, busy, gnt_id
    );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose : round-robin share of one combinational alu between two requesters.
// Latency : req sampled at edge N -> res/done valid after edge N+1; one op per 3 cycles.
// Backpressure: requests are sampled only in IDLE; a losing or busy-time req simply waits.
//
// Ports:
//   clk     : clock, all state on rising edge
//   n_reset : asynchronous active-low reset
//   bus     : alu_arbiter_if.slave (requesters, alu operands/result, status)
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          n_reset,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             winner;
    logic             issue;
    logic             capture;

    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             alu_c_q;
    logic [WIDTH-1:0] res_q;
    logic             done0_q;
    logic             done1_q;
    logic             gnt_q;
    // Owner of the most recent grant; reset to 1 so requester 0 wins the first tie.
    logic             last_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-edge controls
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        capture   = 1'b0;
        winner    = 1'b0;

        // A lone requester always wins; on a tie the one not served last wins.
        if (bus.req0 && bus.req1) begin
            winner = ~last_q;
        end else begin
            winner = bus.req1;
        end

        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    issue     = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, grant and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_c_q <= 1'b0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else if (issue) begin
            // Operands are captured once; the alu sees them stable through EXEC
            // and they stay on the alu inputs until the next issue.
            alu_a_q <= winner ? bus.a1  : bus.a0;
            alu_b_q <= winner ? bus.b1  : bus.b0;
            alu_c_q <= winner ? bus.op1 : bus.op0;
            gnt_q   <= winner;
            last_q  <= winner;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            res_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            if (capture) begin
                res_q <= bus.alu_d;
            end
            // Done is set only on the EXEC->DONE edge, so it clears on the
            // following edge and lasts exactly the DONE cycle.
            done0_q <= capture & ~gnt_q;
            done1_q <= capture &  gnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.alu_a  = alu_a_q;
    assign bus.alu_b  = alu_b_q;
    assign bus.alu_c  = alu_c_q;
    assign bus.res    = res_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.gnt_id = gnt_q;
    assign bus.busy   = (state == EXEC) || (state == DONE);

endmodule
